fp_dispatch: RTL
================

# fp_dispatch

Initiator side of the floating-point add/subtract request interface. Accepts operand pairs from a host through a valid/ready command port and issues one operation at a time to the adder via the `add_serv`/`add_done` handshake. Captures each result, its overflow flag, and a timeout error into a small result FIFO that the host drains. Sits between the host/control logic and the FP adder in the FPU datapath.

## Interface
- `DEPTH`, 4: result FIFO entries; power of 2, at least 2.
- `TIMEOUT`, 64: maximum cycles to wait for `add_done` per request; at least 2.
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `cmd_valid`  in  1  host presents a command.
- `cmd_ready`  out  1  command accepted on a cycle where `cmd_valid & cmd_ready`.
- `cmd_op1`  in  32  IEEE-754 single operand A.
- `cmd_op2`  in  32  IEEE-754 single operand B.
- `cmd_sub`  in  1  1 = compute A − B; 0 = compute A + B.
- `add_serv`  out  1  request to the adder, registered.
- `op1`  out  32  operand A to the adder, registered.
- `op2`  out  32  operand B to the adder, registered; sign is pre-inverted when subtracting.
- `add_result`  in  32  adder result; valid only when `add_done` = 1.
- `add_done`  in  1  one-cycle completion pulse from the adder.
- `add_overflow`  in  1  overflow flag; valid when `add_done` = 1.
- `add_busy`  in  1  adder cannot take a new request.
- `res_valid`  out  1  FIFO is not empty.
- `res_data`  out  32  FIFO head result.
- `res_ovf`  out  1  FIFO head overflow flag.
- `res_err`  out  1  FIFO head timeout flag.
- `res_pop`  in  1  consume the head entry.
- `res_count`  out  $clog2(DEPTH)+1  number of FIFO entries.

## Operation
- **FSM states:** IDLE and REQ.
- **Reset values:** state = IDLE; `add_serv`=0, `op1`=0, `op2`=0; FIFO empty; `res_count`=0; `res_valid`=0; timeout counter = 0. `res_data`, `res_ovf` and `res_err` read 0 while the FIFO is empty.
- **Command acceptance (IDLE):**
  - `cmd_ready` = (state==IDLE) & (`res_count` < DEPTH) & !`add_busy`. It is combinational from registered state plus `add_busy`.
  - On accept, register `op1` = `cmd_op1`.
  - On accept, register `op2` = {`cmd_op2`[31] ^ `cmd_sub`, `cmd_op2`[30:0]}.
  - On accept, set `add_serv`=1, clear the timeout counter, and move to REQ.
- **REQ:**
  - `add_serv` stays 1. `op1`/`op2` are held stable until the request ends.
  - The counter increments every cycle with no `add_done`.
- **REQ, `add_done`=1:**
  - Push {`add_result`, `add_overflow`, err=0}.
  - Set `add_serv`=0 and return to IDLE.
- **REQ, counter reaches TIMEOUT−1 with no `add_done`:**
  - Push {32'h0, ovf=0, err=1}.
  - Set `add_serv`=0 and return to IDLE.
- **Simultaneous completion and timeout:** if `add_done` arrives on the timeout cycle, `add_done` wins and a normal entry is pushed.
- **Stray done:** `add_done` while in IDLE is ignored; nothing is pushed.
- **FIFO space:** a push never overflows, because a command is only accepted when a slot is free and at most one request is outstanding.
- **FIFO indexing:**
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `res_count` is a separate up/down counter.
- **Pop:** `res_pop` with `res_valid`=1 advances the read pointer. `res_pop` with the FIFO empty is ignored.
- **Simultaneous push and pop:** both pointers advance and `res_count` is unchanged. This also holds when the FIFO is full: pop frees a slot and the push occurs the same cycle.
- **Reset mid-request:** return to IDLE, drop `add_serv`, and flush the FIFO. No entry is produced for the aborted request.

## Timing
- Accept at edge N. `add_serv`, `op1` and `op2` are valid after edge N.
- `add_done` sampled at edge N+k (k ≥ 1): the entry is visible (`res_valid`=1 when previously empty) after edge N+k, and `add_serv` is 0 after edge N+k.
- In IDLE after edge N+k, a new command can be accepted at edge N+k+1. Peak throughput is one operation per k+1 cycles.
- Timeout: with no `add_done`, the error entry appears after edge N+TIMEOUT−1 and `add_serv` falls at the same edge.
- `res_data`/`res_ovf`/`res_err` show the head combinationally from FIFO storage. The next head appears the cycle after a pop.

## Test plan
- **Add:** `cmd_op1`=0x3F800000, `cmd_op2`=0x40000000, `cmd_sub`=0. Responder model returns `add_done` 3 cycles later with 0x40400000.
  - Require `op2`=0x40000000 driven and `add_serv` high for exactly 3 cycles.
  - Then `res_valid`=1, `res_data`=0x40400000, `res_err`=0, `res_count`=1.
- **Subtract:** `cmd_op1`=0x40400000, `cmd_op2`=0x3F800000, `cmd_sub`=1.
  - Require `op2`=0xBF800000 driven to the adder.
  - Model returns 0x40000000; FIFO head = 0x40000000.
- **Timeout:** responder never raises `add_done`, TIMEOUT=64.
  - `add_serv` drops after 63 cycles in REQ.
  - Head = {0x00000000, ovf=0, err=1}; the next command is accepted afterwards.
- **Full FIFO:** 4 commands, all completed, no pops.
  - `res_count`=4, `cmd_ready`=0.
  - Pop once: `cmd_ready` returns to 1 and `res_count`=3.
  - Then complete a 5th operation on the same cycle as a pop: `res_count` stays 3 and order is preserved.
- **Busy, stray done, overflow:**
  - `add_busy`=1 holds `cmd_ready`=0.
  - `add_done` pulsed in IDLE causes no push.
  - `add_overflow`=1 with done stores `res_ovf`=1.
- **Reset mid-request:** assert `n_rst`=0 while in REQ with 2 entries queued.
  - Immediately `add_serv`=0, `res_valid`=0, `res_count`=0.
  - After release, state is IDLE and `cmd_ready`=1.

Source files
------------

// File: rtl/fp_dispatch.sv
// Host-side dispatcher for the FP adder: accepts operand pairs, issues one request at a time,
// and queues each result (or timeout error) into a small FIFO for the host to drain.
module fp_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [31:0]                cmd_op1,
    input  logic [31:0]                cmd_op2,
    input  logic                       cmd_sub,
    output logic                       add_serv,
    output logic [31:0]                op1,
    output logic [31:0]                op2,
    input  logic [31:0]                add_result,
    input  logic                       add_done,
    input  logic                       add_overflow,
    input  logic                       add_busy,
    output logic                       res_valid,
    output logic [31:0]                res_data,
    output logic                       res_ovf,
    output logic                       res_err,
    input  logic                       res_pop,
    output logic [$clog2(DEPTH):0]     res_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT) + 1;

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e            state_q, state_d;
    logic              serv_q, serv_d;
    logic [31:0]       op1_q, op1_d;
    logic [31:0]       op2_q, op2_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;

    logic              push;
    logic [31:0]       push_data;
    logic              push_ovf;
    logic              push_err;
    logic              pop;

    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q;
    logic [31:0]       data_mem [DEPTH];
    logic              ovf_mem  [DEPTH];
    logic              err_mem  [DEPTH];

    assign cmd_ready = (state_q == StIdle) && (count_q < CntW'(DEPTH)) && !add_busy;

    always_comb begin
        state_d   = state_q;
        serv_d    = serv_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        push_data = 32'h0;
        push_ovf  = 1'b0;
        push_err  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    op1_d   = cmd_op1;
                    // Subtraction is issued as an add with B's sign flipped.
                    op2_d   = {cmd_op2[31] ^ cmd_sub, cmd_op2[30:0]};
                    serv_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (add_done) begin
                    push      = 1'b1;
                    push_data = add_result;
                    push_ovf  = add_overflow;
                    serv_d    = 1'b0;
                    state_d   = StIdle;
                end else if (tmo_q == TmoW'(TIMEOUT - 2)) begin
                    // Counter would reach TIMEOUT-1 on this edge: give up.
                    push      = 1'b1;
                    push_err  = 1'b1;
                    serv_d    = 1'b0;
                    state_d   = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                serv_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            serv_q  <= 1'b0;
            op1_q   <= 32'h0;
            op2_q   <= 32'h0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            serv_q  <= serv_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            tmo_q   <= tmo_d;
        end
    end

    assign add_serv = serv_q;
    assign op1      = op1_q;
    assign op2      = op2_q;

    assign pop = res_pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr_q] <= push_data;
            ovf_mem[wptr_q]  <= push_ovf;
            err_mem[wptr_q]  <= push_err;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    assign res_valid = (count_q != '0);
    assign res_count = count_q;
    assign res_data  = res_valid ? data_mem[rptr_q] : 32'h0;
    assign res_ovf   = res_valid ? ovf_mem[rptr_q]  : 1'b0;
    assign res_err   = res_valid ? err_mem[rptr_q]  : 1'b0;

endmodule
